// File: rtl/user_flash_pkg.sv
// Shared constants, FSM state type and byte-order helper for the user flash arbiter.
package user_flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ  = 8'h03;
    localparam int         FLASH_XFER_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } flash_state_e;

    // The first byte off the wire lands in the top of the shift register;
    // the bus wants it in the bottom byte.
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/user_flash_shifter.sv
// SPI mode-0 bit engine: prescaler, 64-bit transfer counter, tx/rx shift registers.
// io0 carries the 32-bit command/address word and then zeros; the last 32
// bits sampled from io1 are the read data.
module user_flash_shifter
    import user_flash_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic [31:0] rx_word,
    output logic        done
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BIT_LAST = 6'(FLASH_XFER_BITS - 1);

    logic        active_r;
    logic [7:0]  div_cnt_r;
    logic [5:0]  bit_cnt_r;
    logic        sclk_r;
    logic        mosi_r;
    logic [31:0] tx_r;
    logic [31:0] rx_r;
    logic        done_r;

    // Prescaler, SCLK phase, bit counter and both shift registers.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            active_r  <= 1'b0;
            div_cnt_r <= 8'd0;
            bit_cnt_r <= 6'd0;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            tx_r      <= 32'd0;
            rx_r      <= 32'd0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                active_r  <= 1'b1;
                div_cnt_r <= 8'd0;
                bit_cnt_r <= 6'd0;
                sclk_r    <= 1'b0;
                mosi_r    <= tx_word[31];
                tx_r      <= {tx_word[30:0], 1'b0};
            end else if (active_r) begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_r <= 8'd0;
                    if (!sclk_r) begin
                        // rising SCLK: capture MISO
                        sclk_r <= 1'b1;
                        rx_r   <= {rx_r[30:0], miso};
                    end else begin
                        // falling SCLK: advance to the next bit
                        sclk_r <= 1'b0;
                        if (bit_cnt_r == BIT_LAST) begin
                            active_r <= 1'b0;
                            done_r   <= 1'b1;
                            mosi_r   <= 1'b0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                            mosi_r    <= tx_r[31];
                            tx_r      <= {tx_r[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_r <= div_cnt_r + 8'd1;
                end
            end else begin
                mosi_r <= 1'b0;
            end
        end
    end

    assign sclk    = sclk_r;
    assign mosi    = mosi_r;
    assign rx_word = rx_r;
    assign done    = done_r;

endmodule

// File: rtl/user_flash_arbiter.sv
// Round-robin arbiter sharing the user SPI flash between instruction fetch
// (port 0) and data/wishbone (port 1). One READ command per grant, one word back.
module user_flash_arbiter
    import user_flash_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CSB_IDLE = 2
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    flash_state_e state_r;
    flash_state_e state_s;
    logic         grant_s;
    logic         gnt_port_s;
    logic [31:0]  tx_word_s;
    logic         gap_done_s;
    logic         shift_done_s;
    logic [31:0]  rx_word_s;

    logic         port_r;   // port owning the command in flight
    logic         last_r;   // port granted last; reset to 1 so port 0 wins the first tie
    logic [15:0]  gap_cnt_r;
    logic         csb_r;
    logic         ack0_r;
    logic         ack1_r;
    logic [31:0]  rdata_r;
    logic         busy_r;

    assign gap_done_s = ({16'd0, gap_cnt_r} >= 32'(CSB_IDLE));

    // State register.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic, arbitration and the command word for a new grant.
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        gnt_port_s = 1'b0;
        tx_word_s  = {FLASH_CMD_READ, addr0};
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    grant_s    = 1'b1;
                    gnt_port_s = (req0 && req1) ? ~last_r : req1;
                    tx_word_s  = {FLASH_CMD_READ, gnt_port_s ? addr1 : addr0};
                    state_s    = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (shift_done_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = GAP;
            end
            GAP: begin
                if (gap_done_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Chip select, ack pulses, read data, RR pointer, busy and CSB gap counter.
    always_ff @(posedge clock) begin
        if (!resetb) begin
            csb_r     <= 1'b1;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            rdata_r   <= 32'd0;
            busy_r    <= 1'b0;
            port_r    <= 1'b0;
            last_r    <= 1'b1;
            gap_cnt_r <= 16'd0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            if (grant_s) begin
                csb_r  <= 1'b0;
                busy_r <= 1'b1;
                port_r <= gnt_port_s;
            end else if ((state_r == SHIFT) && shift_done_s) begin
                // entering DONE: the gap is counted from this cycle
                csb_r     <= 1'b1;
                ack0_r    <= ~port_r;
                ack1_r    <= port_r;
                rdata_r   <= byte_swap32(rx_word_s);
                last_r    <= port_r;
                gap_cnt_r <= 16'd1;
            end else if ((state_r == DONE) || (state_r == GAP)) begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
                if (state_s == IDLE) begin
                    busy_r <= 1'b0;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    user_flash_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock   (clock),
        .resetb  (resetb),
        .start   (grant_s),
        .tx_word (tx_word_s),
        .miso    (flash_io1),
        .sclk    (flash_clk),
        .mosi    (flash_io0),
        .rx_word (rx_word_s),
        .done    (shift_done_s)
    );

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;
    assign flash_csb = csb_r;

endmodule
